pc_unit: RTL and testbench

Parametrised fetch-side PC controller for the pipelined SIMD core.
- Computes the decode-stage PC-source flag: PC written as a destination register, or branch.
- Tracks in-flight PC writes through a configurable number of downstream stages.
- Owns the PC register: stalls fetch, flushes decode and redirects to the writeback target.
- Sits between the control-unit decoder and the fetch stage; also feeds the hazard unit.

---
 rtl/pc_pkg.sv | 19 +
 rtl/pcs_tracker.sv | 42 ++++
 rtl/pc_unit.sv | 103 ++++++++++
 tb/tb_pc_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types, default constants and the PC alignment helper for the fetch-side PC controller.
// Optional build macro used by pc_unit: PC_ALIGN_CHECK_EN.
package pc_pkg;

  localparam int PC_W_DEF     = 32;
  localparam int PC_REG_IDX   = 15;
  localparam int RESET_PC_DEF = 0;
  localparam int PC_STEP_DEF  = 4;

  typedef logic [PC_W_DEF-1:0] pc_t;

  // Clears the low log2(step) bits; step is a power of two.
  function automatic pc_t align_pc(pc_t pc, int unsigned step);
    pc_t mask;
    mask = pc_t'(step) - pc_t'(1);
    return pc & ~mask;
  endfunction

endpackage

// File: rtl/pcs_tracker.sv
// Shift register following in-flight PC writes from decode to writeback.
// pending_o covers stages 1..PIPE_DEPTH-1, last_o is the writeback stage.
module pcs_tracker #(
  parameter int PIPE_DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_i,
  output logic pending_o,
  output logic last_o
);

  logic [PIPE_DEPTH:1] pend_reg;
  logic [PIPE_DEPTH:1] pend_next;

  assign pend_next[1] = in_i;

  generate
    for (genvar gi = 2; gi <= PIPE_DEPTH; gi++) begin : g_shift
      assign pend_next[gi] = pend_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg <= '0;
    end else begin
      pend_reg <= pend_next;
    end
  end

  generate
    if (PIPE_DEPTH > 1) begin : g_pending
      assign pending_o = |pend_reg[PIPE_DEPTH-1:1];
    end else begin : g_no_pending
      assign pending_o = 1'b0;
    end
  endgenerate

  assign last_o = pend_reg[PIPE_DEPTH];

endmodule

// File: rtl/pc_unit.sv
// Fetch-side PC controller: PC register, PC-write tracking, fetch stall and decode flush.
// Build macro PC_ALIGN_CHECK_EN adds a sticky misalign_o and aligns redirect targets.
module pc_unit
  import pc_pkg::*;
#(
  parameter int PC_W       = PC_W_DEF,
  parameter int REG_AW     = 5,
  parameter int PC_REG     = PC_REG_IDX,
  parameter int RESET_PC   = RESET_PC_DEF,
  parameter int PC_STEP    = PC_STEP_DEF,
  parameter int PIPE_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_d_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              regw_i,
  input  logic              branch_i,
  input  logic              stall_i,
  input  logic [PC_W-1:0]   pc_target_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [PC_W-1:0]   pc_plus_o,
  output logic              pcs_d_o,
  output logic              pc_wr_pending_o,
  output logic              stall_f_o,
  output logic              flush_d_o,
  output logic              redirect_o
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic              misalign_o
`endif
);

  localparam int ALIGN_W = $clog2(PC_STEP);

  logic [PC_W-1:0] pc_reg;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] load_pc;
  logic            tracker_pending;

  assign pcs_d_o = valid_d_i & (((rd_i == REG_AW'(PC_REG)) & regw_i) | branch_i);

  // A stalled decode must not enter execute, so it becomes a bubble in stage 1.
  pcs_tracker #(
    .PIPE_DEPTH (PIPE_DEPTH)
  ) u_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_i      (pcs_d_o & ~stall_i),
    .pending_o (tracker_pending),
    .last_o    (redirect_o)
  );

  assign pc_wr_pending_o = pcs_d_o | tracker_pending;
  assign stall_f_o       = (pc_wr_pending_o | stall_i) & ~redirect_o;
  assign flush_d_o       = pc_wr_pending_o | redirect_o;
  assign pc_plus_o       = pc_reg + PC_W'(PC_STEP);
  assign pc_o            = pc_reg;

`ifdef PC_ALIGN_CHECK_EN
  generate
    if (ALIGN_W > 0) begin : g_align
      logic misalign_reg;

      assign load_pc = PC_W'(align_pc(pc_t'(pc_target_i), PC_STEP));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          misalign_reg <= 1'b0;
        end else if (redirect_o && (pc_target_i[ALIGN_W-1:0] != '0)) begin
          misalign_reg <= 1'b1;
        end
      end

      assign misalign_o = misalign_reg;
    end else begin : g_no_align
      assign load_pc    = pc_target_i;
      assign misalign_o = 1'b0;
    end
  endgenerate
`else
  assign load_pc = pc_target_i;
`endif

  // Redirect beats any stall so a writeback target is never lost.
  always_comb begin
    pc_next = pc_plus_o;
    if (redirect_o) begin
      pc_next = load_pc;
    end else if (stall_f_o) begin
      pc_next = pc_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= PC_W'(RESET_PC);
    end else begin
      pc_reg <= pc_next;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a due-time reference model queues expected outputs,
// a negedge monitor pops and compares them each cycle.
module tb_pc_unit;

  localparam int D = 3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        pcs;
    logic        pend;
    logic        stall_f;
    logic        flush;
    logic        redir;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_d_i = 1'b0;
  logic [4:0]  rd_i = '0;
  logic        regw_i = 1'b0;
  logic        branch_i = 1'b0;
  logic        stall_i = 1'b0;
  logic [31:0] pc_target_i = '0;
  logic [31:0] pc_o, pc_plus_o;
  logic        pcs_d_o, pc_wr_pending_o, stall_f_o, flush_d_o, redirect_o;
`ifdef PC_ALIGN_CHECK_EN
  logic        misalign_o;
`endif

  pc_unit #(.PIPE_DEPTH(D)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .valid_d_i       (valid_d_i),
    .rd_i            (rd_i),
    .regw_i          (regw_i),
    .branch_i        (branch_i),
    .stall_i         (stall_i),
    .pc_target_i     (pc_target_i),
    .pc_o            (pc_o),
    .pc_plus_o       (pc_plus_o),
    .pcs_d_o         (pcs_d_o),
    .pc_wr_pending_o (pc_wr_pending_o),
    .stall_f_o       (stall_f_o),
    .flush_d_o       (flush_d_o),
    .redirect_o      (redirect_o)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .misalign_o      (misalign_o)
`endif
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Reference model state: PC value, sticky misalign, and the cycles at which
  // each issued PC write is due to reach writeback.
  int          cyc = 0;
  int          due_q[$];
  logic [31:0] m_pc = '0;
  bit          m_mis = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc-entry: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic act_mis;
      e = exp_q.pop_front();
`ifdef PC_ALIGN_CHECK_EN
      act_mis = misalign_o;
`else
      act_mis = 1'b0;
`endif
      $display("t=%0t pc=%h pcs=%b pend=%b stf=%b fl=%b rd=%b", $time, pc_o, pcs_d_o,
               pc_wr_pending_o, stall_f_o, flush_d_o, redirect_o);
      chk("pc_o", pc_o, e.pc);
      chk("pc_plus_o", pc_plus_o, e.pc_plus);
      chk("pcs_d_o", 32'(pcs_d_o), 32'(e.pcs));
      chk("pc_wr_pending_o", 32'(pc_wr_pending_o), 32'(e.pend));
      chk("stall_f_o", 32'(stall_f_o), 32'(e.stall_f));
      chk("flush_d_o", 32'(flush_d_o), 32'(e.flush));
      chk("redirect_o", 32'(redirect_o), 32'(e.redir));
      chk("misalign_o", 32'(act_mis), 32'(e.mis));
    end
  end

  task automatic step(input bit rst, input bit v, input logic [4:0] rd, input bit rw,
                      input bit br, input bit st, input logic [31:0] tgt);
    bit   pcs, redir, pendf, wr_pend, stall_f;
    exp_t e;
    @(posedge clk);
    #1;
    rst_n       = ~rst;
    valid_d_i   = v;
    rd_i        = rd;
    regw_i      = rw;
    branch_i    = br;
    stall_i     = st;
    pc_target_i = tgt;

    if (rst) begin
      due_q.delete();
      m_pc  = 32'h0;
      m_mis = 1'b0;
    end
    pcs   = v && ((rd == 5'd15 && rw) || br);
    redir = 1'b0;
    pendf = 1'b0;
    foreach (due_q[i]) begin
      if (due_q[i] == cyc) redir = 1'b1;
      if (due_q[i] > cyc && due_q[i] < cyc + D) pendf = 1'b1;
    end
    wr_pend = pcs || pendf;
    stall_f = (wr_pend || st) && !redir;
    e.pc      = m_pc;
    e.pc_plus = m_pc + 32'd4;
    e.pcs     = pcs;
    e.pend    = wr_pend;
    e.stall_f = stall_f;
    e.flush   = wr_pend || redir;
    e.redir   = redir;
`ifdef PC_ALIGN_CHECK_EN
    e.mis     = m_mis;
`else
    e.mis     = 1'b0;
`endif
    exp_q.push_back(e);

    if (!rst) begin
      for (int i = due_q.size() - 1; i >= 0; i--) begin
        if (due_q[i] == cyc) due_q.delete(i);
      end
      if (pcs && !st) due_q.push_back(cyc + D);
      if (redir) begin
`ifdef PC_ALIGN_CHECK_EN
        if (tgt[1:0] != 2'b00) m_mis = 1'b1;
        m_pc = {tgt[31:2], 2'b00};
`else
        m_pc = tgt;
`endif
      end else if (!stall_f) begin
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n, input logic [31:0] tgt);
    for (int i = 0; i < n; i++) step(0, 0, 5'd0, 0, 0, 0, tgt);
  endtask

  initial begin
    // Reset, then free-running increment, then asynchronous reset mid-increment
    step(1, 0, 5'd0, 0, 0, 0, 32'h0);
    step(1, 0, 5'd0, 0, 0, 0, 32'h0);
    idle(4, 32'h0);
    step(1, 0, 5'd0, 0, 0, 0, 32'h0);
    idle(3, 32'h0);

    // Branch to 0x100
    step(0, 1, 5'd0, 0, 1, 0, 32'h100);
    idle(5, 32'h100);

    // PC as destination; non-PC destination; PC index without write enable
    step(0, 1, 5'd15, 1, 0, 0, 32'h240);
    idle(5, 32'h240);
    step(0, 1, 5'd14, 1, 0, 0, 32'h0);
    step(0, 1, 5'd15, 0, 0, 0, 32'h0);
    idle(2, 32'h0);

    // Branch held in decode under stall for two cycles, then issued
    step(0, 1, 5'd0, 0, 1, 1, 32'h400);
    step(0, 1, 5'd0, 0, 1, 1, 32'h400);
    step(0, 1, 5'd0, 0, 1, 0, 32'h400);
    idle(5, 32'h400);

    // Redirect coinciding with an external stall
    step(0, 1, 5'd0, 0, 1, 0, 32'h500);
    idle(2, 32'h500);
    step(0, 0, 5'd0, 0, 0, 1, 32'h500);
    idle(3, 32'h500);

    // Back-to-back PC writes
    step(0, 1, 5'd0, 0, 1, 0, 32'h600);
    idle(2, 32'h600);
    step(0, 1, 5'd0, 0, 1, 0, 32'h600);
    idle(5, 32'h700);

    // Wrap-around from 0xFFFFFFFC to 0
    step(0, 1, 5'd0, 0, 1, 0, 32'hFFFF_FFF8);
    idle(6, 32'hFFFF_FFF8);

`ifdef PC_ALIGN_CHECK_EN
    step(0, 1, 5'd0, 0, 1, 0, 32'h102);
    idle(5, 32'h102);
    step(0, 1, 5'd0, 0, 1, 0, 32'h200);
    idle(5, 32'h200);
    step(1, 0, 5'd0, 0, 0, 0, 32'h0);
    idle(2, 32'h0);
`endif

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [4:0]  r_rd;
      logic [31:0] r_tgt;
      r_rd  = 5'($urandom_range(13, 15));
      r_tgt = $urandom;
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), r_rd,
           $urandom_range(0, 1) == 1, ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 5) == 0), r_tgt);
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
